// File: rtl/mpt2042_spi_slave.sv
`timescale 1ns/1ps
// mpt2042_spi_slave
//    Emulates the MPT2042 TDC configuration port so that the SPI master and
//    configuration sequencer can run in loopback without a TDC fitted. SSN,
//    SCLK and MOSI are oversampled on the system clock; MISO is driven in
//    SPI mode 3. A 16x8 register file sits behind the port (address 0 is the
//    read-only device ID) and every accepted write is reported to the fabric.
//
//    Optional feature macro: MPT2042_SLV_ERRCNT_EN
//       defined   : address 4'hF reads a saturating count of framing errors
//                   and ignores writes.
//       undefined : address 4'hF is an ordinary read/write register.
//
// Ports
//    i_clk        system clock (100 MHz)
//    i_rst_n      asynchronous active-low reset
//    i_spi_ssn    slave select, active-low
//    i_spi_clk    SCLK, idles high
//    i_spi_mosi   master-out data
//    o_spi_miso   slave-out data (1 while deselected)
//    o_reg_wr     one-cycle pulse per accepted register write
//    o_reg_addr   address of the last accepted write
//    o_reg_wdata  data of the last accepted write
//    o_frame_done one-cycle pulse at SSN rise after a whole number of bytes
//    o_frame_err  one-cycle pulse at SSN rise with a partial byte pending
//
// FSM states
//    state   | meaning
//    --------+-----------------------------------------------------------
//    IDLE    | deselected, waiting for a synchronized SSN fall
//    CMD     | shifting in the command byte
//    DATA    | data bytes: write to / read from auto-incrementing address

module mpt2042_spi_slave #(
   parameter logic [7:0] DEVICE_ID   = 8'hA5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_spi_ssn,
   input  logic       i_spi_clk,
   input  logic       i_spi_mosi,
   output logic       o_spi_miso,
   output logic       o_reg_wr,
   output logic [3:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_frame_done,
   output logic       o_frame_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [SYNC_STAGES-1:0] ssn_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   ssn_d;
   logic                   sclk_d;
   logic                   ssn_s;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   ssn_rise;
   logic                   ssn_fall;
   logic                   sclk_rise;
   logic                   sclk_fall;

   logic [1:0]             state;
   logic [2:0]             bit_cnt;
   logic [7:0]             rx_sr;
   logic [7:0]             tx_sr;
   logic [3:0]             addr;
   logic                   rd_mode;
   logic                   byte_pend;
   logic                   byte_is_cmd;
   logic [7:0]             regs [1:15];
   logic                   frame_err_evt;
   logic                   addr_writable;
   logic [7:0]             rd_cmd_val;
   logic [7:0]             rd_next_val;
   logic [3:0]             addr_next;

`ifdef MPT2042_SLV_ERRCNT_EN
   logic [7:0]             err_cnt;
`endif

   // SSN synchronizer resets low so a select that is already asserted when
   // reset releases never looks like a fresh falling edge; a real frame can
   // only start after SSN has been seen high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ssn_sync  <= '0;
         sclk_sync <= '1;
         mosi_sync <= '0;
         ssn_d     <= 1'b0;
         sclk_d    <= 1'b1;
      end else begin
         ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], i_spi_ssn};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         ssn_d     <= ssn_s;
         sclk_d    <= sclk_s;
      end
   end

   assign ssn_s     = ssn_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign ssn_rise  = ssn_s & ~ssn_d;
   assign ssn_fall  = ~ssn_s & ssn_d;
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;

   assign frame_err_evt = ssn_rise && (state != ST_IDLE) && (bit_cnt != 3'd0);
   assign addr_next     = addr + 4'd1;

   function automatic logic [7:0] read_reg(input logic [3:0] a);
      logic [7:0] v;
      if (a == 4'h0) begin
         v = DEVICE_ID;
      end else begin
         v = regs[a];
`ifdef MPT2042_SLV_ERRCNT_EN
         if (a == 4'hF) v = err_cnt;
`endif
      end
      return v;
   endfunction

   always_comb begin
      rd_cmd_val    = read_reg(rx_sr[3:0]);
      rd_next_val   = read_reg(addr_next);
      addr_writable = (addr != 4'h0);
`ifdef MPT2042_SLV_ERRCNT_EN
      if (addr == 4'hF) addr_writable = 1'b0;
`endif
   end

`ifdef MPT2042_SLV_ERRCNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_cnt <= 8'h00;
      end else if (frame_err_evt && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= 3'd0;
         rx_sr        <= 8'h00;
         tx_sr        <= 8'h00;
         addr         <= 4'h0;
         rd_mode      <= 1'b0;
         byte_pend    <= 1'b0;
         byte_is_cmd  <= 1'b0;
         o_spi_miso   <= 1'b1;
         o_reg_wr     <= 1'b0;
         o_reg_addr   <= 4'h0;
         o_reg_wdata  <= 8'h00;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         for (int i = 1; i < 16; i++) regs[i] <= 8'h00;
      end else begin
         o_reg_wr     <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         byte_pend    <= 1'b0;

         // SSN rise has priority over any SCLK edge in the same cycle.
         if (ssn_rise) begin
            if (state != ST_IDLE) begin
               o_frame_done <= (bit_cnt == 3'd0);
               o_frame_err  <= (bit_cnt != 3'd0);
            end
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            o_spi_miso <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  bit_cnt    <= 3'd0;
                  o_spi_miso <= 1'b1;
                  if (ssn_fall) begin
                     state      <= ST_CMD;
                     o_spi_miso <= 1'b0;
                  end
               end
               ST_CMD, ST_DATA: begin
                  if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     rx_sr   <= {rx_sr[6:0], mosi_s};
                     if (bit_cnt == 3'd7) begin
                        byte_pend   <= 1'b1;
                        byte_is_cmd <= (state == ST_CMD);
                        state       <= ST_DATA;
                     end
                  end
                  // First fall of a byte presents the freshly loaded MSB;
                  // later falls shift the next bit up.
                  if (sclk_fall && (state == ST_DATA) && rd_mode) begin
                     if (bit_cnt == 3'd0) begin
                        o_spi_miso <= tx_sr[7];
                     end else begin
                        tx_sr      <= {tx_sr[6:0], 1'b0};
                        o_spi_miso <= tx_sr[6];
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end

         // Byte completion is handled one cycle after the 8th rise, once the
         // last bit has landed in rx_sr.
         if (byte_pend) begin
            if (byte_is_cmd) begin
               rd_mode <= rx_sr[7];
               addr    <= rx_sr[3:0];
               tx_sr   <= rd_cmd_val;
            end else begin
               if (!rd_mode && addr_writable) begin
                  regs[addr]  <= rx_sr;
                  o_reg_wr    <= 1'b1;
                  o_reg_addr  <= addr;
                  o_reg_wdata <= rx_sr;
               end
               addr <= addr_next;
               if (rd_mode) tx_sr <= rd_next_val;
            end
         end
      end
   end

endmodule
